adau_frame_sender: RTL and testbench

- Read-side scheduler for the ADAU frame RAM.
- The frame assembler fills the RAM once per second: 65 ADC samples, 2 tacho words, 1 impulse word, then 6×32 ARINC words.
- On a start pulse this block walks the RAM from address 0 to FRAME_LEN-1 and drives the read address. It streams the frame as bytes to the serial transmitter over a valid/ready handshake: sync word first, then the data words, then a 16-bit checksum.

---
 rtl/adau_frame_sender.sv | 151 +++++++++++++++
 tb/tb_adau_frame_sender.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adau_frame_sender.sv
// Read-side scheduler for the ADAU frame RAM: walks the RAM once per start pulse
// and streams sync word, big-endian data words and a 16-bit checksum as bytes.
module adau_frame_sender #(
  parameter int          FRAME_LEN = 260,
  parameter int          ADDR_W    = 9,
  parameter int          RD_LAT    = 2,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clr_ovr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [15:0]       frame_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC_H = 3'd1,
    SYNC_L = 3'd2,
    FETCH  = 3'd3,
    BYTE_H = 3'd4,
    BYTE_L = 3'd5,
    CHK_H  = 3'd6,
    CHK_L  = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_lat;
  logic [15:0]       r_word;
  logic [15:0]       r_chk;
  logic              w_acc;
  logic [15:0]       w_chk_next;

  // Handshake: a byte moves on every rising edge where tx_valid && tx_ready;
  // tx_data/tx_valid are registered and held until that edge, tx_ready is
  // don't-care while tx_valid is low.
  assign w_acc      = tx_valid & tx_ready;
  assign w_chk_next = r_chk + rd_data;
  assign dbg_state  = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_lat     <= '0;
      r_word    <= '0;
      r_chk     <= '0;
      rd_addr   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      // busy is still high on the final checksum-byte cycle, so a start there counts as overrun
      if (start && busy) overrun <= 1'b1;
      else if (clr_ovr)  overrun <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= SYNC_H;
            busy     <= 1'b1;
            r_idx    <= '0;
            r_chk    <= '0;
            tx_valid <= 1'b1;
            tx_data  <= SYNC_WORD[15:8];
          end
        end
        SYNC_H: begin
          if (w_acc) begin
            r_state <= SYNC_L;
            tx_data <= SYNC_WORD[7:0];
          end
        end
        SYNC_L: begin
          if (w_acc) begin
            r_state  <= FETCH;
            tx_valid <= 1'b0;
            rd_addr  <= '0;
            r_lat    <= '0;
          end
        end
        FETCH: begin
          // rd_data is sampled on the last of RD_LAT wait cycles after the address change
          if (r_lat == LAT_LAST) begin
            r_word   <= rd_data;
            r_chk    <= w_chk_next;
            tx_data  <= rd_data[15:8];
            tx_valid <= 1'b1;
            r_state  <= BYTE_H;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        BYTE_H: begin
          if (w_acc) begin
            r_state <= BYTE_L;
            tx_data <= r_word[7:0];
          end
        end
        BYTE_L: begin
          if (w_acc) begin
            if (r_idx == LAST_IDX) begin
              r_state <= CHK_H;
              tx_data <= r_chk[15:8];
            end else begin
              r_state  <= FETCH;
              r_idx    <= r_idx + ADDR_W'(1);
              rd_addr  <= r_idx + ADDR_W'(1);
              r_lat    <= '0;
              tx_valid <= 1'b0;
            end
          end
        end
        CHK_H: begin
          if (w_acc) begin
            r_state <= CHK_L;
            tx_data <= r_chk[7:0];
          end
        end
        CHK_L: begin
          if (w_acc) begin
            r_state   <= IDLE;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adau_frame_sender.sv
// Directed bench for adau_frame_sender: a 4-word frame (RD_LAT=2) and a
// default-size 260-word frame, with byte scoreboards on both instances.
module tb_adau_frame_sender;

  logic clk;
  logic reset;

  // instance A: FRAME_LEN=4, ADDR_W=2, RD_LAT=2
  logic        start_a, clr_a, tx_ready_a;
  logic [1:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic [7:0]  tx_data_a;
  logic        tx_valid_a, busy_a, done_a, overrun_a;
  logic [15:0] frame_cnt_a;
  logic [2:0]  dbg_state_a;

  // instance B: default parameters
  logic        start_b, clr_b, tx_ready_b;
  logic [8:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b, busy_b, done_b, overrun_b;
  logic [15:0] frame_cnt_b;
  logic [2:0]  dbg_state_b;

  adau_frame_sender #(.FRAME_LEN(4), .ADDR_W(2), .RD_LAT(2), .SYNC_WORD(16'hA55A)) dut_a (
    .clock(clk), .reset(reset), .start(start_a), .clr_ovr(clr_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .done(done_a), .overrun(overrun_a), .frame_cnt(frame_cnt_a),
    .dbg_state(dbg_state_a)
  );

  adau_frame_sender dut_b (
    .clock(clk), .reset(reset), .start(start_b), .clr_ovr(clr_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .done(done_b), .overrun(overrun_b), .frame_cnt(frame_cnt_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- RAM models (one pipeline register => RD_LAT=2) ----------------
  logic [15:0] mem_a [4] = '{16'h1234, 16'h00FF, 16'hFFFF, 16'h0002};
  always @(posedge clk) rd_data_a <= mem_a[rd_addr_a];
  always @(posedge clk) rd_data_b <= {7'd0, rd_addr_b};

  // ---------------- scoreboard ----------------
  logic [7:0] exp_qa[$];
  logic [7:0] exp_qb[$];
  logic [7:0] frame_a_bytes [12] = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'h00, 8'hFF,
                                     8'hFF, 8'hFF, 8'h00, 8'h02, 8'h13, 8'h34};
  int n_checks = 0;
  int n_fail   = 0;
  int busy_cyc_a = 0, done_cnt_a = 0;
  int busy_cyc_b = 0, bytes_b = 0;
  logic       hold_a = 1'b0;
  logic [7:0] hold_data_a = '0;
  logic       toggle_a = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitors sample 1 ns after the falling edge; drivers act at falling edge (+2 ns in tasks)
  always begin
    logic [7:0] e;
    @(negedge clk); #1;
    if (busy_a) busy_cyc_a++;
    if (done_a) done_cnt_a++;
    if (!reset) begin
      if (hold_a) begin
        check("a_hold_valid", {31'd0, tx_valid_a}, 32'd1);
        check("a_hold_data", {24'd0, tx_data_a}, {24'd0, hold_data_a});
      end
      if (tx_valid_a && tx_ready_a) begin
        if (exp_qa.size() > 0) e = exp_qa.pop_front();
        else e = 'x;
        check("a_byte", {24'd0, tx_data_a}, {24'd0, e});
      end
      hold_a      = tx_valid_a && !tx_ready_a;
      hold_data_a = tx_data_a;
    end else begin
      hold_a = 1'b0;
    end
  end

  always begin
    logic [7:0] e;
    @(negedge clk); #1;
    if (busy_b) busy_cyc_b++;
    if (!reset && tx_valid_b && tx_ready_b) begin
      bytes_b++;
      if (exp_qb.size() > 0) e = exp_qb.pop_front();
      else e = 'x;
      check("b_byte", {24'd0, tx_data_b}, {24'd0, e});
    end
  end

  // ready generator for instance A: held high, or toggled every cycle
  initial begin
    tx_ready_a = 1'b1;
    forever begin
      @(negedge clk);
      if (toggle_a) tx_ready_a = ~tx_ready_a;
      else          tx_ready_a = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk); #2;
    end
  endtask

  task automatic push_frame_a();
    foreach (frame_a_bytes[i]) exp_qa.push_back(frame_a_bytes[i]);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!done_a && n < budget);
    check(tag, {31'd0, done_a}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] sum_b;
    int n;
    reset = 1'b1;
    start_a = 1'b0; clr_a = 1'b0;
    start_b = 1'b0; clr_b = 1'b0; tx_ready_b = 1'b1;
    step(3);

    check("rst_rd_addr", {30'd0, rd_addr_a}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data_a}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_overrun", {31'd0, overrun_a}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt_a}, 32'd0);
    check("rst_state", {29'd0, dbg_state_a}, 32'd0);
    reset = 1'b0;
    step(2);

    // frame 1: tx_ready held high
    push_frame_a();
    busy_cyc_a = 0; done_cnt_a = 0;
    pulse_start_a();
    wait_done_a("f1_done_seen", 100);
    check("f1_busy_in_done", {31'd0, busy_a}, 32'd0);
    check("f1_frame_cnt", {16'd0, frame_cnt_a}, 32'd1);
    check("f1_busy_cycles", busy_cyc_a, 32'd20);
    step(3);
    check("f1_done_pulses", done_cnt_a, 32'd1);
    check("f1_bytes_left", exp_qa.size(), 32'd0);
    check("f1_rd_addr_hold", {30'd0, rd_addr_a}, 32'd3);

    // frame 2: tx_ready toggling, plus a start while busy
    toggle_a = 1'b1;
    push_frame_a();
    pulse_start_a();
    step(10);
    pulse_start_a();
    check("f2_overrun_set", {31'd0, overrun_a}, 32'd1);
    wait_done_a("f2_done_seen", 200);
    toggle_a = 1'b0;
    step(2);
    check("f2_frame_cnt", {16'd0, frame_cnt_a}, 32'd2);
    check("f2_bytes_left", exp_qa.size(), 32'd0);
    check("f2_overrun_sticky", {31'd0, overrun_a}, 32'd1);

    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    check("clr_overrun", {31'd0, overrun_a}, 32'd0);

    // frame 3: busy start and clear in the same cycle
    push_frame_a();
    pulse_start_a();
    step(5);
    start_a = 1'b1; clr_a = 1'b1;
    step(1);
    start_a = 1'b0; clr_a = 1'b0;
    check("ovr_set_wins", {31'd0, overrun_a}, 32'd1);
    wait_done_a("f3_done_seen", 100);
    check("f3_frame_cnt", {16'd0, frame_cnt_a}, 32'd3);
    step(2);
    check("f3_bytes_left", exp_qa.size(), 32'd0);

    // reset during BYTE_L of word 2
    push_frame_a();
    pulse_start_a();
    n = 0;
    while (!(dbg_state_a == 3'd5 && rd_addr_a == 2'd2) && n < 100) begin
      step(1);
      n++;
    end
    check("rst_mid_reached", {29'd0, dbg_state_a}, 32'd5);
    reset = 1'b1;
    done_cnt_a = 0;
    step(1);
    check("rst_mid_tx_valid", {31'd0, tx_valid_a}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    check("rst_mid_frame_cnt", {16'd0, frame_cnt_a}, 32'd0);
    check("rst_mid_overrun", {31'd0, overrun_a}, 32'd0);
    check("rst_mid_tx_data", {24'd0, tx_data_a}, 32'd0);
    reset = 1'b0;
    exp_qa.delete();
    step(6);
    check("rst_mid_no_done", done_cnt_a, 32'd0);

    push_frame_a();
    pulse_start_a();
    wait_done_a("f4_done_seen", 100);
    check("f4_frame_cnt", {16'd0, frame_cnt_a}, 32'd1);
    step(2);
    check("f4_bytes_left", exp_qa.size(), 32'd0);

    // frame counter wrap, then a start in the done cycle
    push_frame_a();
    pulse_start_a();
    step(3);
    force dut_a.frame_cnt = 16'hFFFF;
    step(1);
    release dut_a.frame_cnt;
    step(1);
    check("wrap_preload", {16'd0, frame_cnt_a}, 32'h0000_FFFF);
    wait_done_a("f5_done_seen", 100);
    check("wrap_frame_cnt", {16'd0, frame_cnt_a}, 32'd0);
    push_frame_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    check("done_start_busy", {31'd0, busy_a}, 32'd1);
    check("done_start_no_ovr", {31'd0, overrun_a}, 32'd0);
    wait_done_a("f6_done_seen", 100);
    check("f6_frame_cnt", {16'd0, frame_cnt_a}, 32'd1);
    check("f6_overrun", {31'd0, overrun_a}, 32'd0);
    step(2);
    check("f6_bytes_left", exp_qa.size(), 32'd0);

    // default-size frame, RAM word n = n
    sum_b = 16'h0000;
    exp_qb.push_back(8'hA5);
    exp_qb.push_back(8'h5A);
    for (int i = 0; i < 260; i++) begin
      exp_qb.push_back(8'(i >> 8));
      exp_qb.push_back(8'(i & 255));
      sum_b = sum_b + 16'(i);
    end
    exp_qb.push_back(sum_b[15:8]);
    exp_qb.push_back(sum_b[7:0]);
    busy_cyc_b = 0; bytes_b = 0;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!done_b && n < 3000);
    check("b_done_seen", {31'd0, done_b}, 32'd1);
    check("b_busy_cycles", busy_cyc_b, 32'd1044);
    check("b_byte_count", bytes_b, 32'd524);
    check("b_rd_addr_last", {23'd0, rd_addr_b}, 32'd259);
    check("b_frame_cnt", {16'd0, frame_cnt_b}, 32'd1);
    check("b_bytes_left", exp_qb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
